// File: rtl/io_pkg.sv
// Shared types and header-field constants for the IO feeder receive path.
// Also imported by the feeder-side bench so both agree on the header layout.
package io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } rx_state_t;

    typedef enum logic {
        HALF_LO,
        HALF_HI
    } half_sel_t;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 16;

endpackage

// File: rtl/io_rx_fifo.sv
// Synchronous word FIFO. Exposes the head and the entry behind it so the
// writer can move to the next word in the same cycle it retires the head.
module io_rx_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rd_data_next,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the count gates every read, so stale
    // contents are never observed and the array maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_data      = mem_q[rd_ptr_q];
    assign rd_data_next = mem_q[PTR_W'(rd_ptr_q + 1'b1)];
    assign count        = count_q;
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);

endmodule

// File: rtl/io_receiver.sv
// Receiving end of the IO feeder bus: header-counted transfers of 32-bit
// words, written low half first into 16-bit solver memory.
module io_receiver
    import io_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int HALF_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intrpt,
    input  logic              ld,
    input  logic [DATA_W-1:0] dataBus,
    output logic              rdy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [HALF_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [15:0]       word_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_t             state_q, state_d;
    logic [HDR_LEN_W-1:0]  remaining_q, remaining_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [HALF_W-1:0]     mem_wdata_q, mem_wdata_d;
    half_sel_t             half_q, half_d;

    logic                  push_acc;
    logic                  wr_accept;
    logic                  wr_load;
    logic                  drain_clear;
    logic [DATA_W-1:0]     src_word;
    logic [HDR_LEN_W-1:0]  hdr_len;

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_W-1:0]     fifo_head;
    logic [DATA_W-1:0]     fifo_head_next;

    io_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push_acc),
        .push_data    (dataBus),
        .pop          (fifo_pop),
        .rd_data      (fifo_head),
        .rd_data_next (fifo_head_next),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    assign rdy       = (state_q == ST_HEADER) || ((state_q == ST_DATA) && !fifo_full);
    assign push_acc  = (state_q == ST_DATA) && ld && rdy;
    assign hdr_len   = dataBus[HDR_LEN_LSB +: HDR_LEN_W];

    // The word being written stays at the FIFO head until its high half is
    // accepted, so FIFO occupancy covers the in-flight word as well.
    assign wr_accept = mem_we_q && mem_ready;
    assign fifo_pop  = wr_accept && (half_q == HALF_HI);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        half_d      = half_q;
        wr_load     = 1'b0;
        src_word    = fifo_head;

        if (wr_accept) begin
            mem_addr_d = mem_addr_q + 1'b1;
            wr_load    = 1'b1;
            if (half_q == HALF_LO) begin
                half_d = HALF_HI;
            end else begin
                half_d = HALF_LO;
                if (fifo_count > CNT_W'(1)) begin
                    src_word = fifo_head_next;
                end else if (push_acc) begin
                    src_word = dataBus;
                end else begin
                    mem_we_d = 1'b0;
                    wr_load  = 1'b0;
                end
            end
        end else if (!mem_we_q) begin
            half_d = HALF_LO;
            if (!fifo_empty) begin
                mem_we_d = 1'b1;
                wr_load  = 1'b1;
            end else if (push_acc) begin
                src_word = dataBus;
                mem_we_d = 1'b1;
                wr_load  = 1'b1;
            end
        end

        if (wr_load) begin
            mem_wdata_d = (half_d == HALF_HI) ? src_word[DATA_W-1:HALF_W]
                                              : src_word[HALF_W-1:0];
        end

        if ((state_q == ST_IDLE) && intrpt) begin
            mem_addr_d = ADDR_W'(BASE_ADDR);
        end
    end

    // Drain finishes in the cycle the final high half is accepted.
    assign drain_clear = (fifo_empty && !mem_we_q) ||
                         ((fifo_count == CNT_W'(1)) && fifo_pop);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        word_cnt_d  = word_cnt_q;
        err_ovf_d   = err_ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (intrpt) begin
                    state_d    = ST_HEADER;
                    word_cnt_d = '0;
                    err_ovf_d  = 1'b0;
                end
            end
            ST_HEADER: begin
                if (ld) begin
                    remaining_d = hdr_len;
                    state_d     = (hdr_len == '0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (push_acc) begin
                    word_cnt_d  = word_cnt_q + 16'd1;
                    remaining_d = remaining_q - HDR_LEN_W'(1);
                    if (remaining_q == HDR_LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end else if (ld) begin
                    err_ovf_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_clear) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            word_cnt_q  <= '0;
            err_ovf_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_W'(BASE_ADDR);
            mem_wdata_q <= '0;
            half_q      <= HALF_LO;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            word_cnt_q  <= word_cnt_d;
            err_ovf_q   <= err_ovf_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            half_q      <= half_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err_ovf   = err_ovf_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_io_receiver.sv
// Randomized bench for io_receiver: a transaction-level model (word queue,
// half index, write address) predicts every output on every cycle.
module tb_io_receiver;

    localparam int DATA_W     = 32;
    localparam int HALF_W     = 16;
    localparam int ADDR_W     = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int BASE_ADDR  = 0;

    localparam int P_IDLE  = 0;
    localparam int P_HDR   = 1;
    localparam int P_DATA  = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              intrpt = 1'b0;
    logic              ld = 1'b0;
    logic [DATA_W-1:0] data_bus = '0;
    logic              mem_ready = 1'b0;
    logic              rdy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [HALF_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              err_ovf;
    logic [15:0]       word_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_phase = P_IDLE;
    int          m_rem   = 0;
    int          m_cnt   = 0;
    bit          m_err   = 1'b0;
    int          m_addr  = BASE_ADDR;
    bit          m_hi    = 1'b0;
    logic [31:0] m_q[$];

    io_receiver #(
        .DATA_W     (DATA_W),
        .HALF_W     (HALF_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .intrpt    (intrpt),
        .ld        (ld),
        .dataBus   (data_bus),
        .rdy       (rdy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err_ovf   (err_ovf),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        return (m_phase == P_HDR) || ((m_phase == P_DATA) && (m_q.size() < FIFO_DEPTH));
    endfunction

    task automatic check_outputs();
        logic [31:0] head;
        check("rdy", {31'b0, rdy}, {31'b0, model_rdy()});
        check("busy", {31'b0, busy}, {31'b0, m_phase != P_IDLE});
        check("done", {31'b0, done}, {31'b0, m_phase == P_DONE});
        check("mem_we", {31'b0, mem_we}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            head = m_q[0];
            check("mem_addr", {20'b0, mem_addr}, m_addr);
            check("mem_wdata", {16'b0, mem_wdata}, {16'b0, m_hi ? head[31:16] : head[15:0]});
        end
        check("err_ovf", {31'b0, err_ovf}, {31'b0, m_err});
        check("word_cnt", {16'b0, word_cnt}, m_cnt);
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step();
        bit cur_rdy;
        bit push;
        int n;
        if (rst) begin
            m_phase = P_IDLE;
            m_rem   = 0;
            m_cnt   = 0;
            m_err   = 1'b0;
            m_addr  = BASE_ADDR;
            m_hi    = 1'b0;
            m_q.delete();
            return;
        end
        cur_rdy = model_rdy();
        push    = (m_phase == P_DATA) && ld && cur_rdy;
        if ((m_q.size() != 0) && mem_ready) begin
            m_addr = (m_addr + 1) % (1 << ADDR_W);
            if (m_hi) begin
                void'(m_q.pop_front());
                m_hi = 1'b0;
            end else begin
                m_hi = 1'b1;
            end
        end
        if (push) m_q.push_back(data_bus);
        case (m_phase)
            P_IDLE: if (intrpt) begin
                m_phase = P_HDR;
                m_cnt   = 0;
                m_err   = 1'b0;
                m_addr  = BASE_ADDR;
            end
            P_HDR: if (ld) begin
                n       = int'(data_bus[15:0]);
                m_rem   = n;
                m_phase = (n == 0) ? P_DONE : P_DATA;
            end
            P_DATA: begin
                if (push) begin
                    m_cnt++;
                    m_rem--;
                    if (m_rem == 0) m_phase = P_DRAIN;
                end else if (ld) begin
                    m_err = 1'b1;
                end
            end
            P_DRAIN: if (m_q.size() == 0) m_phase = P_DONE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_xfer(input int n, input int rdy_pct, input bit honor, input int stall);
        logic [15:0] len;
        bit          saw_done;
        bit          finished;
        len      = n[15:0];
        saw_done = 1'b0;
        finished = 1'b0;
        ld       = 1'b0;
        intrpt   = 1'b1;
        cycle();
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            mem_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            intrpt    = ($urandom_range(7) == 0);
            if (m_phase == P_HDR) begin
                ld       = $urandom_range(1);
                data_bus = {$urandom_range(16'hffff), len};
            end else begin
                ld       = honor ? (rdy && ($urandom_range(3) != 0)) : 1'b1;
                data_bus = $urandom;
            end
            if (m_phase == P_DONE) saw_done = 1'b1;
            cycle();
            if (saw_done && m_phase == P_IDLE) finished = 1'b1;
        end
        intrpt = 1'b0;
        ld     = 1'b0;
        check("xfer_timeout", {31'b0, finished}, 32'd1);
        check("xfer_word_cnt", {16'b0, word_cnt}, n);
    endtask

    task automatic idle_gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            intrpt    = 1'b0;
            ld        = $urandom_range(1);
            data_bus  = $urandom;
            mem_ready = $urandom_range(1);
            cycle();
        end
        ld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        idle_gap(3);

        run_xfer(2, 100, 1'b1, 0);
        idle_gap(2);
        run_xfer(0, 100, 1'b1, 0);
        idle_gap(2);
        run_xfer(6, 100, 1'b1, 10);
        check("honor_no_ovf", {31'b0, err_ovf}, 32'd0);
        idle_gap(2);
        run_xfer(9, 100, 1'b0, 10);
        check("flood_ovf", {31'b0, err_ovf}, 32'd1);
        idle_gap(2);

        for (int t = 0; t < 24; t++) begin
            run_xfer($urandom_range(12), $urandom_range(100, 20), $urandom_range(1), $urandom_range(6));
            idle_gap($urandom_range(3));
        end

        // Long transfer crosses the address wrap at 2^ADDR_W half-words.
        run_xfer(2100, 100, 1'b1, 0);
        idle_gap(2);

        // Reset in the middle of a data phase.
        intrpt = 1'b1;
        cycle();
        intrpt    = 1'b0;
        ld        = 1'b1;
        data_bus  = 32'h0000_0008;
        mem_ready = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            data_bus = $urandom;
            cycle();
        end
        ld  = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", {20'b0, mem_addr}, BASE_ADDR);
        check("rst_cnt", {16'b0, word_cnt}, 32'd0);
        idle_gap(2);
        run_xfer(1, 100, 1'b1, 0);
        idle_gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
